// File: rtl/isa_pkg.sv
// Shared fetch-path widths and the entry format held by the prefetch queue.
package isa_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular buffer of fetch entries with read/write pointers and an occupancy count.
// Reset and flush both clear pointers and count; stored words are left as-is.
module sync_fifo
    import isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  fetch_entry_t             wr_data,
    output fetch_entry_t             rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Prefetch queue between the PC/instruction memory and decode.
// Decode handshake: an entry transfers on a cycle where DecValid && DecReady && !Flush.
module instruction_fetch_buffer
    import isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [ADDR_W-1:0]      FetchPC,
    input  logic [INSTR_W-1:0]     FetchInstr,
    input  logic                   Flush,
    input  logic                   DecReady,
    output logic                   DecValid,
    output logic [INSTR_W-1:0]     DecInstr,
    output logic [ADDR_W-1:0]      DecPC,
    output logic [ADDR_W-1:0]      DecPCPlus4,
    output logic                   PCWrite,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic         enq;
    logic         deq;
    fetch_entry_t in_entry;
    fetch_entry_t head;

    assign in_entry = '{pc: FetchPC, instr: FetchInstr};

    // No bypass: a full queue never enqueues, even when it dequeues the same cycle.
    assign enq = !Flush && (Count < FULL);
    assign deq = !Flush && DecValid && DecReady;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (Clk),
        .rst     (Reset),
        .flush   (Flush),
        .wr_en   (enq),
        .rd_en   (deq),
        .wr_data (in_entry),
        .rd_data (head),
        .count   (Count)
    );

    assign DecValid   = (Count != '0);
    assign PCWrite    = (Count == FULL) && !Flush;
    assign DecInstr   = DecValid ? head.instr : '0;
    assign DecPC      = DecValid ? head.pc : '0;
    assign DecPCPlus4 = DecValid ? (head.pc + PC_INCR) : '0;

endmodule
